// File: rtl/trigger_window_reader.sv
// Trigger-aligned ADC capture: circular sample RAM, trigger qualification and AXIS window readout.
// Optional build macro TRIG_READER_HEADER_EN prepends one beat carrying trig_addr.
module trigger_window_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_LEN   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_data_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  trigger,
  input  logic                  arm,
  input  logic [ADDR_LEN-1:0]   pre_samples,
  input  logic [ADDR_LEN-1:0]   post_samples,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_LEN-1:0]   trig_addr,
  output logic                  busy,
  output logic                  done
);
  localparam int DEPTH = 1 << ADDR_LEN;
`ifdef TRIG_READER_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam logic [ADDR_LEN:0] EXTRA = (ADDR_LEN+1)'(HDR_EN ? 2 : 1);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_POST, S_READOUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data;
  logic [ADDR_LEN-1:0]   wr_addr, fill_cnt, pre, post_n, post_cnt, rd_ptr, post_clamp;
  logic [ADDR_LEN:0]     win_sum, rd_left;
  logic                  writing, we, arm_ok, trig_ok, post_done;
  logic                  hdr_pend, issue, rd_en, infl, infl_hdr, infl_last, pop;
  logic [1:0]            occ, sk_cnt;
  logic [DATA_WIDTH-1:0] sk_data [2];
  logic [1:0]            sk_last;
  logic                  sk_head, sk_tail;

  assign writing   = (state == S_IDLE) || (state == S_ARMED) || (state == S_POST);
  assign we        = in_data_valid && writing;
  assign arm_ok    = arm && writing;
  assign trig_ok   = (state == S_ARMED) && !arm && trigger && in_data_valid && (fill_cnt >= pre);
  assign post_done = we && (state == S_POST) && ((post_cnt + 1'b1) == post_n);

  // Window must fit in the RAM: the sum's carry bit means PRE + POST_N + 1 > DEPTH.
  assign win_sum    = {1'b0, pre} + {1'b0, post_n};
  assign post_clamp = win_sum[ADDR_LEN] ? ~pre : post_n;

  assign pop   = m_axis_tvalid && m_axis_tready;
  assign occ   = sk_cnt + {1'b0, infl};
  assign issue = (state == S_READOUT) && (rd_left != '0) && ((occ < 2'd2) || ((occ == 2'd2) && pop));
  assign rd_en = issue && !hdr_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (arm) state_nxt = S_ARMED;
      S_ARMED: begin
        if (arm)          state_nxt = S_ARMED;
        else if (trig_ok) state_nxt = (post_clamp == '0) ? S_READOUT : S_POST;
      end
      S_POST: begin
        if (arm)            state_nxt = S_ARMED;
        else if (post_done) state_nxt = S_READOUT;
      end
      S_READOUT: if (pop && m_axis_tlast) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_addr   <= '0;
      fill_cnt  <= '0;
      trig_addr <= '0;
      pre       <= '0;
      post_n    <= '0;
      post_cnt  <= '0;
      rd_ptr    <= '0;
      rd_left   <= '0;
      hdr_pend  <= 1'b0;
      infl      <= 1'b0;
      infl_hdr  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      state <= state_nxt;
      if (we) wr_addr <= wr_addr + 1'b1;
      if (arm_ok) begin
        pre      <= pre_samples;
        post_n   <= post_samples;
        fill_cnt <= '0;
      end else if (we && (fill_cnt != '1)) begin
        fill_cnt <= fill_cnt + 1'b1;
      end
      if (trig_ok) begin
        trig_addr <= wr_addr;
        post_cnt  <= '0;
        post_n    <= post_clamp;
        rd_ptr    <= wr_addr - pre;
        rd_left   <= {1'b0, pre} + {1'b0, post_clamp} + EXTRA;
        hdr_pend  <= HDR_EN;
      end else if (we && (state == S_POST)) begin
        post_cnt <= post_cnt + 1'b1;
      end
      infl      <= issue;
      infl_hdr  <= hdr_pend;
      infl_last <= (rd_left == (ADDR_LEN+1)'(1));
      if (issue) begin
        rd_left <= rd_left - 1'b1;
        if (hdr_pend) hdr_pend <= 1'b0;
        else          rd_ptr   <= rd_ptr + 1'b1;
      end
    end
  end

  // Sample RAM: contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we && !rst) mem[wr_addr] <= in_data;
    if (rd_en)      rd_data      <= mem[rd_ptr];
  end

  // Two-entry skid; reads are only issued when a slot is guaranteed for the returning data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sk_cnt  <= '0;
      sk_head <= 1'b0;
      sk_tail <= 1'b0;
      sk_last <= '0;
      for (int i = 0; i < 2; i++) sk_data[i] <= '0;
    end else begin
      if (infl) begin
        sk_data[sk_tail] <= infl_hdr ? DATA_WIDTH'(trig_addr) : rd_data;
        sk_last[sk_tail] <= infl_last;
        sk_tail          <= ~sk_tail;
      end
      if (pop) sk_head <= ~sk_head;
      sk_cnt <= sk_cnt + {1'b0, infl} - {1'b0, pop};
    end
  end

  assign m_axis_tvalid = (sk_cnt != '0);
  assign m_axis_tdata  = sk_data[sk_head];
  assign m_axis_tlast  = m_axis_tvalid && sk_last[sk_head];
  assign busy          = (state != S_IDLE);
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_trigger_window_reader.sv
// Directed bench for trigger_window_reader (ADDR_LEN = 6) with a continuous ramp input.
module tb_trigger_window_reader;
  localparam int AW = 6;
  localparam int DW = 16;
`ifdef TRIG_READER_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_data_valid, trigger, arm, m_axis_tready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] pre_samples, post_samples, trig_addr;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid, m_axis_tlast, busy, done;

  trigger_window_reader #(.DATA_WIDTH(DW), .ADDR_LEN(AW)) dut (
    .clk(clk), .rst(rst), .in_data_valid(in_data_valid), .in_data(in_data),
    .trigger(trigger), .arm(arm), .pre_samples(pre_samples), .post_samples(post_samples),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .trig_addr(trig_addr), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ramp, cycle, done_cnt, bp_phase;
  bit bp_mode, stall_prev;
  logic [DW-1:0] stall_data;
  logic          stall_last;
  logic [DW-1:0] bq_data[$];
  logic          bq_last[$];
  int            bq_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at the falling edge, observe outputs launched by the previous rising edge.
  task automatic cyc(input bit trig, input bit armp);
    in_data_valid = 1'b1;
    in_data       = DW'(ramp);
    trigger       = trig;
    arm           = armp;
    m_axis_tready = bp_mode ? ((bp_phase % 4 == 0) || (bp_phase % 4 == 3)) : 1'b1;
    if (stall_prev) begin
      chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
      chk("stall_tdata", 32'(m_axis_tdata), 32'(stall_data));
      chk("stall_tlast", 32'(m_axis_tlast), 32'(stall_last));
    end
    stall_prev = m_axis_tvalid && !m_axis_tready;
    stall_data = m_axis_tdata;
    stall_last = m_axis_tlast;
    if (m_axis_tvalid && m_axis_tready) begin
      bq_data.push_back(m_axis_tdata);
      bq_last.push_back(m_axis_tlast);
      bq_cyc.push_back(cycle);
    end
    if (done) done_cnt++;
    ramp++;
    cycle++;
    bp_phase++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; in_data_valid = 1'b0;
    in_data = '0; m_axis_tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_case(input string nm, input int pre, input int post, input int tv,
                          input int ev, input bit bpm, input bit abort);
    int exp_post, nb, trig_cyc, lat, n;
    logic [31:0] exp_d;
    do_reset();
    pre_samples  = AW'(pre);
    post_samples = AW'(post);
    ramp = 0; cycle = 0; done_cnt = 0; bp_phase = 0;
    bp_mode = bpm; stall_prev = 1'b0;
    bq_data.delete(); bq_last.delete(); bq_cyc.delete();
    exp_post = (pre + post + 1 > 64) ? 63 - pre : post;
    nb       = pre + exp_post + 1 + HDR;
    trig_cyc = 0;
    for (n = 0; n < 400; n++) begin
      if (ramp == tv) trig_cyc = cycle;
      cyc((ramp == tv) || (ramp == ev), n == 0);
      if (abort && bq_data.size() > 0) break;
      if (done_cnt > 0) begin
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        break;
      end
    end
    if (abort) begin
      chk({nm, "_abort_started"}, 32'(bq_data.size() > 0), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk({nm, "_abort_tvalid"}, 32'(m_axis_tvalid), 32'd0);
      chk({nm, "_abort_busy"}, 32'(busy), 32'd0);
      chk({nm, "_abort_trig_addr"}, 32'(trig_addr), 32'd0);
      rst = 1'b0;
      return;
    end
    chk({nm, "_beats"}, 32'(bq_data.size()), 32'(nb));
    for (int i = 0; i < nb && i < bq_data.size(); i++) begin
      exp_d = (HDR == 1 && i == 0) ? 32'(tv % 64) : 32'(tv - pre + i - HDR);
      chk($sformatf("%s_data%0d", nm, i), 32'(bq_data[i]), exp_d);
      chk($sformatf("%s_last%0d", nm, i), 32'(bq_last[i]), 32'(i == nb - 1));
    end
    chk({nm, "_done_pulses"}, 32'(done_cnt), 32'd1);
    chk({nm, "_busy_after"}, 32'(busy), 32'd0);
    chk({nm, "_trig_addr"}, 32'(trig_addr), 32'(tv % 64));
    if (!bpm && bq_data.size() == nb) begin
      chk({nm, "_no_bubbles"}, 32'(bq_cyc[nb-1] - bq_cyc[0]), 32'(nb - 1));
      lat = bq_cyc[0] - trig_cyc;
      chk({nm, "_first_beat_latency_ok"}, 32'(lat <= exp_post + 4), 32'd1);
    end
  endtask

  initial begin
    pre_samples = '0; post_samples = '0;
    do_reset();
    chk("reset_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("reset_tlast", 32'(m_axis_tlast), 32'd0);
    chk("reset_tdata", 32'(m_axis_tdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_trig_addr", 32'(trig_addr), 32'd0);

    run_case("basic",    4,  3, 20, -1, 1'b0, 1'b0);
    run_case("early",   10,  2, 13,  6, 1'b0, 1'b0);
    run_case("wrap",     8,  2, 67, -1, 1'b0, 1'b0);
    run_case("bp",       4,  3, 20, -1, 1'b1, 1'b0);
    run_case("zero",     0,  0,  5, -1, 1'b0, 1'b0);
    run_case("clamp",   40, 40, 50, -1, 1'b0, 1'b0);
    run_case("abort",    4,  3, 20, -1, 1'b0, 1'b1);
    run_case("rearm",    4,  3, 20, -1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
